// File: rtl/sqmux_pkg.sv
// Shared types and constants for the SQMUX select controller.
package sqmux_pkg;

  localparam int CNT_W = 8;

  localparam logic SEL_QMUXIN = 1'b0;
  localparam logic SEL_SQHSCK = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    SWAP,
    SETTLE
  } state_e;

endpackage

// File: rtl/sqmux_hold_cnt.sv
// Loadable down-counter with a "last" flag; holds at zero instead of wrapping.
module sqmux_hold_cnt
  import sqmux_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The owning FSM leaves its hold state on this flag, so the count never reaches zero mid-hold.
  assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/sqmux_sel_ctrl.sv
// Glitch-free SELECT sequencer for SQMUX: gate both sources, swap, settle, re-enable.
// Optional LOCK input is built when SQMUX_SEL_CTRL_LOCK_EN is defined.
module sqmux_sel_ctrl
  import sqmux_pkg::*;
#(
  parameter int unsigned GATE_CYCLES   = 4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic   CLK,
  input  logic   RST,
  input  logic   REQ_VALID,
  input  logic   REQ_SEL,
  output logic   REQ_READY,
  output logic   SELECT,
  output logic   QMUXIN_EN,
  output logic   SQHSCK_EN,
  output logic   BUSY,
  output logic   DONE,
  output state_e dbg_state_o
`ifdef SQMUX_SEL_CTRL_LOCK_EN
  ,
  input  logic   LOCK
`endif
);

  localparam logic [CNT_W-1:0] G_VAL = CNT_W'(GATE_CYCLES);
  localparam logic [CNT_W-1:0] S_VAL = CNT_W'(SETTLE_CYCLES);

  // Handshake: a request is taken on any edge where REQ_VALID && REQ_READY;
  // REQ_SEL is sampled only then, and requests offered while not ready are dropped.

  state_e           state_q, state_d;
  logic             sel_q, sel_d;
  logic             tgt_q, tgt_d;
  logic             qen_q, qen_d;
  logic             sen_q, sen_d;
  logic             done_q, done_d;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_dec;
  logic             cnt_last;
  logic             lock_w;
  logic             accept;

`ifdef SQMUX_SEL_CTRL_LOCK_EN
  assign lock_w = LOCK;
`else
  assign lock_w = 1'b0;
`endif

  assign REQ_READY = (state_q == IDLE) && !lock_w;
  assign accept    = REQ_VALID && REQ_READY;

  sqmux_hold_cnt u_hold_cnt (
    .clk_i      (CLK),
    .rst_i      (RST),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .last_o     (cnt_last)
  );

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    tgt_d    = tgt_q;
    qen_d    = qen_q;
    sen_d    = sen_q;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = G_VAL;
    cnt_dec  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (REQ_SEL == sel_q) begin
            done_d = 1'b1;
          end else begin
            tgt_d    = REQ_SEL;
            state_d  = DRAIN;
            cnt_load = 1'b1;
            cnt_val  = G_VAL;
            qen_d    = 1'b0;
            sen_d    = 1'b0;
          end
        end
      end
      DRAIN: begin
        cnt_dec = 1'b1;
        if (cnt_last) begin
          state_d = SWAP;
          // Registered here so SELECT is already new during the SWAP cycle.
          sel_d   = tgt_q;
        end
      end
      SWAP: begin
        cnt_load = 1'b1;
        cnt_val  = S_VAL;
        state_d  = SETTLE;
      end
      SETTLE: begin
        cnt_dec = 1'b1;
        if (cnt_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
          qen_d   = (sel_q == SEL_QMUXIN);
          sen_d   = (sel_q == SEL_SQHSCK);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      sel_q   <= SEL_QMUXIN;
      tgt_q   <= SEL_QMUXIN;
      qen_q   <= 1'b1;
      sen_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      tgt_q   <= tgt_d;
      qen_q   <= qen_d;
      sen_q   <= sen_d;
      done_q  <= done_d;
    end
  end

  assign SELECT      = sel_q;
  assign QMUXIN_EN   = qen_q;
  assign SQHSCK_EN   = sen_q;
  assign BUSY        = (state_q != IDLE);
  assign DONE        = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/sqmux_sel_ctrl.md
# sqmux_sel_ctrl

Single-clock controller that drives the SELECT pin of the SQMUX clock mux. It also drives the source-gate enables for the QMUXIN and SQHSCK branches, so a source change never presents a runt pulse at IZ. It accepts switch requests over a valid/ready handshake and sequences gate-off, select change, settle and gate-on. It sits directly upstream of SQMUX in the AP3 clock-network primitives and runs on a free-running control clock that is independent of both muxed clocks.

## Interface
Parameters:
- GATE_CYCLES, 4, number of CLK cycles both sources stay gated before SELECT changes; legal range 1..255.
- SETTLE_CYCLES, 2, number of CLK cycles both sources stay gated after SELECT changes; legal range 1..255.

Ports:
- CLK  in  1  control clock, free-running.
- RST  in  1  reset, synchronous, active-high.
- REQ_VALID  in  1  switch request.
- REQ_SEL  in  1  target source: 0 = QMUXIN, 1 = SQHSCK.
- REQ_READY  out  1  request accepted when REQ_VALID && REQ_READY.
- SELECT  out  1  to SQMUX.SELECT; registered.
- QMUXIN_EN  out  1  gate enable for the QMUXIN source; registered.
- SQHSCK_EN  out  1  gate enable for the SQHSCK source; registered.
- BUSY  out  1  high while a switch sequence is in progress.
- DONE  out  1  one-cycle completion pulse.
- LOCK  in  1  blocks new requests; present only with SQMUX_SEL_CTRL_LOCK_EN.

## Operation
- Reset values: SELECT=0, QMUXIN_EN=1, SQHSCK_EN=0, REQ_READY=1, BUSY=0, DONE=0, state IDLE, counter 0.
- **IDLE:**
  - REQ_READY=1. Exactly one of QMUXIN_EN and SQHSCK_EN is high, matching SELECT.
  - If the accepted REQ_SEL equals SELECT, the request is a no-op: DONE pulses next cycle and the state stays IDLE.
  - If REQ_SEL differs from SELECT: latch the target, go to DRAIN, load counter with GATE_CYCLES.
- **DRAIN:** both enables 0, BUSY=1, REQ_READY=0. Count down; on the last count go to SWAP.
- **SWAP** (1 cycle): SELECT takes the latched target. Enables stay 0. Load counter with SETTLE_CYCLES.
- **SETTLE:** enables 0. Count down; on the last count go to IDLE. In the same transition, raise the enable matching the new SELECT and pulse DONE.
- REQ_VALID while REQ_READY=0 is ignored (not queued). REQ_SEL is sampled only on acceptance.
- The invariant QMUXIN_EN && SQHSCK_EN is never 1.
- SELECT changes only in SWAP.

## Timing
For a request accepted at cycle t, with G = GATE_CYCLES and S = SETTLE_CYCLES:
- t+1 .. t+G: DRAIN; both enables 0.
- t+G+1: SWAP; SELECT is new from this cycle.
- t+G+2 .. t+G+S+1: SETTLE.
- t+G+S+2: IDLE; new enable=1, DONE=1, REQ_READY=1, BUSY=0.
- Latency from accept to DONE is G+S+2 cycles. A new request may be accepted in the DONE cycle.
- No-op request accepted at t: DONE=1 at t+1, no other output changes.

Reset:
- RST wins over every other input in the same cycle.
- RST mid-sequence restores the reset values on the next edge, including SELECT=0 and QMUXIN_EN=1. Any gating in progress is abandoned.

Counter:
- 8-bit, no wrap.
- Must not under-flow: the transition is taken when the counter equals 1.

## Configuration
- Macro SQMUX_SEL_CTRL_LOCK_EN.
- **Defined:** LOCK port exists. While LOCK=1, REQ_READY=0 in IDLE. LOCK has no effect on a sequence already in progress.
- **Undefined:** no LOCK port; the block behaves as if LOCK=0.

## Structure
- Shared package sqmux_pkg holds:
  - state enum typedef (IDLE, DRAIN, SWAP, SETTLE);
  - SEL_QMUXIN=1'b0 and SEL_SQHSCK=1'b1;
  - counter width constant (8).
- One sub-module, sqmux_hold_cnt: loadable down-counter with a "last" flag, shared between DRAIN and SETTLE.

## Test plan
All scenarios use G=4, S=2.
- **Reset:** assert RST for 2 cycles → SELECT=0, QMUXIN_EN=1, SQHSCK_EN=0, REQ_READY=1, DONE=0.
- **Switch to SQHSCK:** REQ_SEL=1 accepted at t → enables both 0 at t+1..t+7; SELECT=1 from t+5; SQHSCK_EN=1 and DONE=1 at t+8.
- **No-op:** with SELECT=1, request REQ_SEL=1 → DONE at t+1; no enable or SELECT toggle.
- **Back-to-back:** request during DRAIN is ignored (REQ_READY=0). A request held through the DONE cycle is accepted, and switching back to QMUXIN completes 8 cycles later.
- **Reset mid-SETTLE:** RST during SETTLE → next cycle SELECT=0, QMUXIN_EN=1, BUSY=0, no DONE.
- **LOCK** (macro defined): LOCK=1 with REQ_VALID=1 for 10 cycles → REQ_READY=0, no change. Deassert LOCK → accepted the following cycle.
